// File: rtl/alu_ex_stage.sv
// alu_ex_stage: ALU execute stage with a registered valid/ready output.
// The output uses a two-entry skid buffer (out reg + skid reg), so in_ready_o
// is driven straight from a flop. Retired results are counted in a wrapping counter.
// Optional feature macro: ALU_EX_OVF_FLAG_EN adds ovf_o, the signed overflow of
// ADD/SUB, which is carried through the buffer alongside the result.
module alu_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       alu_ctrl_i,
  input  logic [XLEN-1:0]  op_a_i,
  input  logic [XLEN-1:0]  op_b_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic             zero_o,
  output logic [CNT_W-1:0] op_count_o
`ifdef ALU_EX_OVF_FLAG_EN
  ,
  output logic             ovf_o
`endif
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;

  // One buffered result; the flags travel with it so they always match.
  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            zero;
`ifdef ALU_EX_OVF_FLAG_EN
    logic            ovf;
`endif
  } entry_t;

  logic            out_v_q, out_v_d;
  logic            skid_v_q, skid_v_d;
  entry_t          out_e_q, out_e_d;
  entry_t          skid_e_q, skid_e_d;
  logic            in_ready_q;
  logic [CNT_W-1:0] op_count_q;

  logic [XLEN-1:0] sum, diff, alu_res;
  entry_t          new_e;
  logic            accept, retire;

  assign sum    = op_a_i + op_b_i;
  assign diff   = op_a_i - op_b_i;
  assign accept = in_valid_i & in_ready_q;
  assign retire = out_v_q & out_ready_i;

  // ALU datapath; unknown codes fall back to ADD like the decoder does.
  always_comb begin
    alu_res = sum;
    unique case (alu_ctrl_i)
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = op_a_i & op_b_i;
      OP_OR:   alu_res = op_a_i | op_b_i;
      OP_XOR:  alu_res = op_a_i ^ op_b_i;
      default: alu_res = sum;
    endcase
  end

  // Pack the freshly computed result with its flags.
  always_comb begin
    new_e      = '0;
    new_e.res  = alu_res;
    new_e.zero = (alu_res == '0);
`ifdef ALU_EX_OVF_FLAG_EN
    unique case (alu_ctrl_i)
      OP_SUB:
        new_e.ovf = (op_a_i[XLEN-1] != op_b_i[XLEN-1]) && (diff[XLEN-1] != op_a_i[XLEN-1]);
      OP_AND, OP_OR, OP_XOR:
        new_e.ovf = 1'b0;
      default:
        new_e.ovf = (op_a_i[XLEN-1] == op_b_i[XLEN-1]) && (sum[XLEN-1] != op_a_i[XLEN-1]);
    endcase
`endif
  end

  // Skid-buffer routing. Flush wins; a full skid drains before anything new is
  // taken (in_ready is low then, so accept and skid-drain never coincide).
  always_comb begin
    out_v_d  = out_v_q;
    skid_v_d = skid_v_q;
    out_e_d  = out_e_q;
    skid_e_d = skid_e_q;
    if (flush_i) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (retire && skid_v_q) begin
      out_e_d  = skid_e_q;
      skid_v_d = 1'b0;
    end else if (accept) begin
      if (!out_v_q || retire) begin
        out_e_d = new_e;
        out_v_d = 1'b1;
      end else begin
        skid_e_d = new_e;
        skid_v_d = 1'b1;
      end
    end else if (retire) begin
      out_v_d = 1'b0;
    end
  end

  // Buffer state; in_ready is registered as "skid will be empty".
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_v_q      <= 1'b0;
      skid_v_q     <= 1'b0;
      in_ready_q   <= 1'b1;
      out_e_q      <= '0;
      out_e_q.zero <= 1'b1;
      skid_e_q     <= '0;
    end else begin
      out_v_q    <= out_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= !skid_v_d;
      out_e_q    <= out_e_d;
      skid_e_q   <= skid_e_d;
    end
  end

  // Retired-op counter: wraps, survives flush, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       op_count_q <= '0;
    else if (retire) op_count_q <= op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_v_q;
  assign result_o    = out_e_q.res;
  assign zero_o      = out_e_q.zero;
  assign op_count_o  = op_count_q;
`ifdef ALU_EX_OVF_FLAG_EN
  assign ovf_o       = out_e_q.ovf;
`endif

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage with a FIFO scoreboard (CNT_W=4 to reach wrap).
module tb_alu_ex_stage;
  localparam int XLEN = 32;
  localparam int CW   = 4;

  logic            clk, rst, in_valid, in_ready, flush, out_valid, out_ready, zero;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] op_a, op_b, result;
  logic [CW-1:0]   op_count;
`ifdef ALU_EX_OVF_FLAG_EN
  logic            ovf;
`endif

  alu_ex_stage #(.XLEN(XLEN), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .alu_ctrl_i(alu_ctrl), .op_a_i(op_a), .op_b_i(op_b), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
    .zero_o(zero), .op_count_o(op_count)
`ifdef ALU_EX_OVF_FLAG_EN
    , .ovf_o(ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0] r;
    logic            z;
    logic            o;
  } exp_t;

  exp_t          q[$];
  logic [CW-1:0] cnt_m;
  int            checks   = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] s, d;
    s = a + b;
    d = a - b;
    e.o = 1'b0;
    case (c)
      4'd1: begin e.r = d; e.o = (a[31] != b[31]) && (d[31] != a[31]); end
      4'd2: e.r = a & b;
      4'd3: e.r = a | b;
      4'd4: e.r = a ^ b;
      default: begin e.r = s; e.o = (a[31] == b[31]) && (s[31] != a[31]); end
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    in_valid = v; alu_ctrl = c; op_a = a; op_b = b;
  endtask

  // Check at mid-cycle, update the scoreboard with this cycle's handshakes, advance one edge.
  task automatic step();
    logic acc, ret;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("op_count", 64'(op_count), 64'(cnt_m));
    if (q.size() > 0) begin
      chk("result", 64'(result), 64'(q[0].r));
      chk("zero", 64'(zero), 64'(q[0].z));
`ifdef ALU_EX_OVF_FLAG_EN
      chk("ovf", 64'(ovf), 64'(q[0].o));
`endif
    end
    acc = in_valid && in_ready && !flush;
    ret = out_valid && out_ready;
    if (ret) cnt_m = cnt_m + 1'b1;
    if (flush) q.delete();
    else begin
      if (ret && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(model(alu_ctrl, op_a, op_b));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [CW-1:0]   cnt0;
    logic [XLEN-1:0] res0;
    cnt_m = '0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_op_count", 64'(op_count), 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: ADD 5+7 with consumer ready
    out_ready = 1'b1;
    drive(1'b1, 4'd0, 32'd5, 32'd7); step();
    chk("t1_result", 64'(result), 64'd12);
    drive(1'b0, 4'd0, 32'd0, 32'd0); step();
    chk("t1_op_count", 64'(op_count), 64'd1);

    // 2: SUB to zero, SUB underflow, signed-overflow ADD
    drive(1'b1, 4'd1, 32'h10, 32'h10); step();
    drive(1'b1, 4'd1, 32'd0, 32'd1); step();
    drive(1'b1, 4'd0, 32'h7FFFFFFF, 32'd1); step();
    drive(1'b0, 4'd0, 32'd0, 32'd0); step(); step();

    // 3: stall, fill both entries, hold third beat, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 4'd2, 32'hF0F0, 32'hFF00); step();
    drive(1'b1, 4'd3, 32'hF0F0, 32'hFF00); step();
    chk("t3_in_ready_low", 64'(in_ready), 64'd0);
    drive(1'b1, 4'd4, 32'hF0F0, 32'hFF00); step();
    out_ready = 1'b1;
    step();
    chk("t3_first_out", 64'(result), 64'hFFF0);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0); step(); step();

    // 4: flush with both entries full and a beat presented
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 32'd1, 32'd2); step();
    drive(1'b1, 4'd0, 32'd3, 32'd4); step();
    cnt0 = op_count; res0 = result;
    flush = 1'b1;
    drive(1'b1, 4'd4, 32'h55, 32'hAA); step();
    flush = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    chk("t4_in_ready", 64'(in_ready), 64'd1);
    chk("t4_op_count", 64'(op_count), 64'(cnt0));
    chk("t4_result_stale", 64'(result), 64'(res0));
    step();

    // 5: undefined code behaves as ADD
    out_ready = 1'b1;
    drive(1'b1, 4'd7, 32'd3, 32'd4); step();
    chk("t5_result", 64'(result), 64'd7);
    drive(1'b0, 4'd0, 32'd0, 32'd0); step();

    // 6: async reset mid-stream, checked before any edge
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 32'd9, 32'd9); step(); step();
    #2 rst = 1'b1;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    chk("t6_op_count", 64'(op_count), 64'd0);
    chk("t6_result", 64'(result), 64'd0);
    chk("t6_zero", 64'(zero), 64'd1);
    q.delete(); cnt_m = '0;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // counter wrap: 17 retires with CNT_W=4 -> 1
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 4'd0, 32'(i), 32'd1); step();
    end
    drive(1'b0, 4'd0, 32'd0, 32'd0); step(); step();
    chk("wrap_op_count", 64'(op_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
